// File: rtl/alu_arbiter_if.sv
// Request/response channels between the two ALU clients and alu_arbiter.
// The arbiter uses the slave modport; each client side uses master.
interface alu_arbiter_if #(
    parameter int CONTROL_BITS = 3,
    parameter int DATA_WIDTH   = 32
);
    logic                    req_valid_0;
    logic                    req_valid_1;
    logic                    req_ready_0;
    logic                    req_ready_1;
    logic [CONTROL_BITS-1:0] req_op_0;
    logic [CONTROL_BITS-1:0] req_op_1;
    logic [DATA_WIDTH-1:0]   req_a_0;
    logic [DATA_WIDTH-1:0]   req_a_1;
    logic [DATA_WIDTH-1:0]   req_b_0;
    logic [DATA_WIDTH-1:0]   req_b_1;
    logic                    rsp_valid_0;
    logic                    rsp_valid_1;
    logic                    rsp_ready_0;
    logic                    rsp_ready_1;
    logic [DATA_WIDTH-1:0]   rsp_result_0;
    logic [DATA_WIDTH-1:0]   rsp_result_1;
    logic                    rsp_zero_0;
    logic                    rsp_zero_1;

    modport master (
        output req_valid_0, req_valid_1, req_op_0, req_op_1,
               req_a_0, req_a_1, req_b_0, req_b_1,
               rsp_ready_0, rsp_ready_1,
        input  req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1,
               rsp_result_0, rsp_result_1, rsp_zero_0, rsp_zero_1
    );

    modport slave (
        input  req_valid_0, req_valid_1, req_op_0, req_op_1,
               req_a_0, req_a_1, req_b_0, req_b_1,
               rsp_ready_0, rsp_ready_1,
        output req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1,
               rsp_result_0, rsp_result_1, rsp_zero_0, rsp_zero_1
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter for two clients sharing one integer ALU: accept, execute
// from latched operands, then hold the result until the winner consumes it.
module alu_arbiter #(
    parameter int CONTROL_BITS = 3,
    parameter int DATA_WIDTH   = 32
) (
    input  logic         clk,
    input  logic         reset,
    alu_arbiter_if.slave bus,
    output logic         busy
);
    localparam logic [CONTROL_BITS-1:0] OP_ADD = CONTROL_BITS'(0);
    localparam logic [CONTROL_BITS-1:0] OP_SUB = CONTROL_BITS'(1);
    localparam logic [CONTROL_BITS-1:0] OP_AND = CONTROL_BITS'(2);
    localparam logic [CONTROL_BITS-1:0] OP_OR  = CONTROL_BITS'(3);
    localparam logic [CONTROL_BITS-1:0] OP_SLT = CONTROL_BITS'(5);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t                  state, state_next;
    logic                    grant_id;
    logic                    ptr;
    logic                    win;
    logic                    accept;
    logic                    done;

    logic [CONTROL_BITS-1:0] op_p0;
    logic [DATA_WIDTH-1:0]   a_p0;
    logic [DATA_WIDTH-1:0]   b_p0;
    logic [DATA_WIDTH-1:0]   result_p1;
    logic                    zero_p1;

    logic                    req_ready_0, req_ready_1;
    logic                    rsp_valid_0, rsp_valid_1;
    logic [DATA_WIDTH-1:0]   rsp_result_0, rsp_result_1;
    logic                    rsp_zero_0, rsp_zero_1;

    // Unknown codes fall to zero so the zero flag reads 1 for them.
    function automatic logic [DATA_WIDTH-1:0] alu_eval(
        input logic [CONTROL_BITS-1:0] op,
        input logic [DATA_WIDTH-1:0]   a,
        input logic [DATA_WIDTH-1:0]   b
    );
        logic [DATA_WIDTH-1:0] r;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_SLT:  r = {{(DATA_WIDTH-1){1'b0}}, (a < b)};
            default: r = '0;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next  = state;
        win         = ptr;
        accept      = 1'b0;
        done        = 1'b0;
        req_ready_0 = 1'b0;
        req_ready_1 = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req_valid_0 || bus.req_valid_1) begin
                    win        = (bus.req_valid_0 && bus.req_valid_1) ? ptr : bus.req_valid_1;
                    accept     = 1'b1;
                    state_next = EXEC;
                    if (win) req_ready_1 = 1'b1;
                    else     req_ready_0 = 1'b1;
                end
            end
            EXEC: state_next = RESP;
            RESP: begin
                if (grant_id ? bus.rsp_ready_1 : bus.rsp_ready_0) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (reset) begin
            accept      = 1'b0;
            done        = 1'b0;
            req_ready_0 = 1'b0;
            req_ready_1 = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr      <= 1'b0;
            grant_id <= 1'b0;
        end else begin
            if (accept) grant_id <= win;
            if (done)   ptr      <= ~grant_id;
        end
    end

    // Stage p0: operands of the accepted request
    always_ff @(posedge clk) begin
        if (accept) begin
            op_p0 <= win ? bus.req_op_1 : bus.req_op_0;
            a_p0  <= win ? bus.req_a_1  : bus.req_a_0;
            b_p0  <= win ? bus.req_b_1  : bus.req_b_0;
        end
    end

    // Stage p1: ALU result held for the whole response phase
    always_ff @(posedge clk) begin
        if (state == EXEC) begin
            result_p1 <= alu_eval(op_p0, a_p0, b_p0);
            zero_p1   <= (alu_eval(op_p0, a_p0, b_p0) == '0);
        end
    end

    always_comb begin
        rsp_valid_0  = 1'b0;
        rsp_valid_1  = 1'b0;
        rsp_result_0 = '0;
        rsp_result_1 = '0;
        rsp_zero_0   = 1'b0;
        rsp_zero_1   = 1'b0;
        if (state == RESP && !reset) begin
            if (grant_id) begin
                rsp_valid_1  = 1'b1;
                rsp_result_1 = result_p1;
                rsp_zero_1   = zero_p1;
            end else begin
                rsp_valid_0  = 1'b1;
                rsp_result_0 = result_p1;
                rsp_zero_0   = zero_p1;
            end
        end
    end

    assign bus.req_ready_0  = req_ready_0;
    assign bus.req_ready_1  = req_ready_1;
    assign bus.rsp_valid_0  = rsp_valid_0;
    assign bus.rsp_valid_1  = rsp_valid_1;
    assign bus.rsp_result_0 = rsp_result_0;
    assign bus.rsp_result_1 = rsp_result_1;
    assign bus.rsp_zero_0   = rsp_zero_0;
    assign bus.rsp_zero_1   = rsp_zero_1;
    assign busy             = (state != IDLE) && !reset;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: arbitration order, latency, back-pressure,
// ALU corner cases and mid-transaction reset.
module tb_alu_arbiter;
    logic clk = 1'b0;
    logic reset;
    logic busy;
    int   tests = 0;
    int   fails = 0;

    alu_arbiter_if #(.CONTROL_BITS(3), .DATA_WIDTH(32)) bus ();

    alu_arbiter #(.CONTROL_BITS(3), .DATA_WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Single r0 transaction with rsp_ready_0 high; starts in IDLE, ends in IDLE.
    task automatic run_r0(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] res, input logic zero);
        bus.req_valid_0 = 1'b1;
        bus.req_op_0    = op;
        bus.req_a_0     = a;
        bus.req_b_0     = b;
        bus.rsp_ready_0 = 1'b1;
        #1;
        chk({tag, "_ready"}, bus.req_ready_0, 1'b1);
        tick();
        bus.req_valid_0 = 1'b0;
        tick();
        chk({tag, "_valid"}, bus.rsp_valid_0, 1'b1);
        chk({tag, "_result"}, bus.rsp_result_0, res);
        chk({tag, "_zero"}, bus.rsp_zero_0, zero);
        tick();
    endtask

    initial begin
        reset = 1'b1;
        bus.req_valid_0 = 1'b0; bus.req_valid_1 = 1'b0;
        bus.req_op_0 = '0; bus.req_op_1 = '0;
        bus.req_a_0 = '0; bus.req_a_1 = '0; bus.req_b_0 = '0; bus.req_b_1 = '0;
        bus.rsp_ready_0 = 1'b0; bus.rsp_ready_1 = 1'b0;
        tick();
        tick();
        // Requests during reset are ignored
        bus.req_valid_0 = 1'b1;
        #1;
        chk("rst_ready0", bus.req_ready_0, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rsp_valid0", bus.rsp_valid_0, 1'b0);
        tick();
        bus.req_valid_0 = 1'b0;
        reset = 1'b0;
        #1;
        chk("post_rst_busy", busy, 1'b0);
        chk("post_rst_rsp_valid1", bus.rsp_valid_1, 1'b0);
        tick();

        // r0 ADD 5+7, accept cycle 0, response cycle 2
        bus.req_valid_0 = 1'b1; bus.req_op_0 = 3'b000; bus.req_a_0 = 32'd5; bus.req_b_0 = 32'd7;
        bus.rsp_ready_0 = 1'b1;
        #1;
        chk("add_ready0", bus.req_ready_0, 1'b1);
        chk("add_ready1", bus.req_ready_1, 1'b0);
        chk("add_busy_c0", busy, 1'b0);
        tick();
        bus.req_valid_0 = 1'b0;
        chk("add_busy_c1", busy, 1'b1);
        chk("add_valid_c1", bus.rsp_valid_0, 1'b0);
        tick();
        chk("add_valid_c2", bus.rsp_valid_0, 1'b1);
        chk("add_result", bus.rsp_result_0, 32'd12);
        chk("add_zero", bus.rsp_zero_0, 1'b0);
        chk("add_valid1", bus.rsp_valid_1, 1'b0);
        chk("add_result1", bus.rsp_result_1, 32'd0);
        tick();
        chk("add_idle_valid", bus.rsp_valid_0, 1'b0);
        chk("add_idle_busy", busy, 1'b0);

        // r1 alone wins even though the pointer now favours it; pointer returns to r0
        bus.req_valid_1 = 1'b1; bus.req_op_1 = 3'b010; bus.req_a_1 = 32'hFF00; bus.req_b_1 = 32'h0FF0;
        bus.rsp_ready_1 = 1'b1;
        #1;
        chk("and_ready1", bus.req_ready_1, 1'b1);
        chk("and_ready0", bus.req_ready_0, 1'b0);
        tick();
        bus.req_valid_1 = 1'b0;
        tick();
        chk("and_valid1", bus.rsp_valid_1, 1'b1);
        chk("and_result", bus.rsp_result_1, 32'h0F00);
        chk("and_valid0", bus.rsp_valid_0, 1'b0);
        tick();

        // Simultaneous: r0 SUB 3-3 first, r1 OR next
        bus.req_valid_0 = 1'b1; bus.req_op_0 = 3'b001; bus.req_a_0 = 32'd3; bus.req_b_0 = 32'd3;
        bus.req_valid_1 = 1'b1; bus.req_op_1 = 3'b011; bus.req_a_1 = 32'hF0; bus.req_b_1 = 32'h0F;
        #1;
        chk("both_ready0", bus.req_ready_0, 1'b1);
        chk("both_ready1", bus.req_ready_1, 1'b0);
        tick();
        bus.req_valid_0 = 1'b0;
        #1;
        chk("both_exec_ready1", bus.req_ready_1, 1'b0);
        tick();
        chk("sub_valid", bus.rsp_valid_0, 1'b1);
        chk("sub_result", bus.rsp_result_0, 32'd0);
        chk("sub_zero", bus.rsp_zero_0, 1'b1);
        chk("sub_resp_ready1", bus.req_ready_1, 1'b0);
        tick();
        chk("or_ready1", bus.req_ready_1, 1'b1);
        tick();
        bus.req_valid_1 = 1'b0;
        tick();
        chk("or_valid", bus.rsp_valid_1, 1'b1);
        chk("or_result", bus.rsp_result_1, 32'hFF);
        chk("or_zero", bus.rsp_zero_1, 1'b0);
        tick();

        // Back-pressure on r0 for 4 cycles while r1 waits
        bus.req_valid_0 = 1'b1; bus.req_op_0 = 3'b000; bus.req_a_0 = 32'h10; bus.req_b_0 = 32'h20;
        bus.req_valid_1 = 1'b1; bus.req_op_1 = 3'b000; bus.req_a_1 = 32'd1; bus.req_b_1 = 32'd1;
        bus.rsp_ready_0 = 1'b0;
        #1;
        chk("bp_ready0", bus.req_ready_0, 1'b1);
        tick();
        bus.req_valid_0 = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("bp_hold_valid", bus.rsp_valid_0, 1'b1);
            chk("bp_hold_result", bus.rsp_result_0, 32'h30);
            chk("bp_hold_ready1", bus.req_ready_1, 1'b0);
            tick();
        end
        bus.rsp_ready_0 = 1'b1;
        #1;
        chk("bp_hs_valid", bus.rsp_valid_0, 1'b1);
        chk("bp_hs_ready1", bus.req_ready_1, 1'b0);
        tick();
        chk("bp_r1_granted", bus.req_ready_1, 1'b1);
        tick();
        bus.req_valid_1 = 1'b0;
        tick();
        chk("bp_r1_result", bus.rsp_result_1, 32'd2);
        tick();

        // Six back-to-back transactions with both clients always valid
        bus.req_valid_0 = 1'b1; bus.req_valid_1 = 1'b1;
        bus.req_op_0 = 3'b000; bus.req_op_1 = 3'b000;
        bus.req_b_0 = 32'd0; bus.req_b_1 = 32'd0;
        for (int i = 0; i < 6; i++) begin
            bus.req_a_0 = 32'(i + 1);
            bus.req_a_1 = 32'(32'h100 + i);
            #1;
            chk("rr_ready0", bus.req_ready_0, (i % 2) == 0);
            chk("rr_ready1", bus.req_ready_1, (i % 2) == 1);
            tick();
            tick();
            if ((i % 2) == 0) chk("rr_result0", bus.rsp_result_0, 32'(i + 1));
            else              chk("rr_result1", bus.rsp_result_1, 32'(32'h100 + i));
            tick();
        end
        bus.req_valid_0 = 1'b0; bus.req_valid_1 = 1'b0;
        tick();

        run_r0("slt_big", 3'b101, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1);
        run_r0("slt_small", 3'b101, 32'd1, 32'd2, 32'd1, 1'b0);
        run_r0("code100", 3'b100, 32'd9, 32'd9, 32'd0, 1'b1);
        run_r0("add_wrap", 3'b000, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1);
        run_r0("sub_wrap", 3'b001, 32'd0, 32'd1, 32'hFFFFFFFF, 1'b0);
        run_r0("code111", 3'b111, 32'd4, 32'd6, 32'd0, 1'b1);

        // Reset during EXEC drops the transaction and clears the pointer
        bus.req_valid_0 = 1'b1; bus.req_op_0 = 3'b000; bus.req_a_0 = 32'd1; bus.req_b_0 = 32'd1;
        tick();
        bus.req_valid_0 = 1'b0;
        chk("mid_busy_exec", busy, 1'b1);
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 1'b0);
        tick();
        reset = 1'b0;
        #1;
        chk("mid_after_busy", busy, 1'b0);
        chk("mid_after_valid", bus.rsp_valid_0, 1'b0);
        tick();
        chk("mid_no_rsp", bus.rsp_valid_0, 1'b0);
        bus.req_valid_0 = 1'b1; bus.req_op_0 = 3'b011; bus.req_a_0 = 32'hA0; bus.req_b_0 = 32'h05;
        bus.req_valid_1 = 1'b1;
        #1;
        chk("mid_grant0", bus.req_ready_0, 1'b1);
        chk("mid_grant1", bus.req_ready_1, 1'b0);
        tick();
        bus.req_valid_0 = 1'b0; bus.req_valid_1 = 1'b0;
        tick();
        chk("mid_result", bus.rsp_result_0, 32'hA5);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
